// File: rtl/sha256_msg_padder_pkg.sv
// Shared constants for the SHA-256 message padder: FSM encodings, block geometry
// and the padding/length field layout.
package sha256_msg_padder_pkg;
   localparam int BLK_WORDS   = 16;
   localparam int BYTE_LANES  = 4;
   localparam int LEN_FIELD_W = 64;
   localparam int CNT_EXT_W   = LEN_FIELD_W - 3;
   localparam int LEN_WORD_HI = 14;
   localparam int LEN_WORD_LO = 15;
   localparam logic [7:0] PAD_BYTE = 8'h80;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_FILL = 3'd1;
   localparam logic [2:0] ST_EMIT = 3'd2;
   localparam logic [2:0] ST_PAD  = 3'd3;
   localparam logic [2:0] ST_LEN  = 3'd4;

   // Byte count to the 64-bit bit-length field appended at the end of the message.
   function automatic logic [LEN_FIELD_W-1:0] bit_len(input logic [CNT_EXT_W-1:0] bytes);
      return {bytes, 3'b000};
   endfunction
endpackage

// File: rtl/sha256_msg_padder_if.sv
// Byte-stream input and word-serial block output of the padder, in one bundle.
interface sha256_msg_padder_if;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_last;
   logic        in_keep;
   logic        in_ready;
   logic        blk_valid;
   logic        blk_ready;
   logic [31:0] blk_word;
   logic [3:0]  blk_idx;
   logic        blk_sof;
   logic        blk_eom;

   modport master (output in_valid, in_data, in_last, in_keep, blk_ready,
                   input  in_ready, blk_valid, blk_word, blk_idx, blk_sof, blk_eom);
   modport slave  (input  in_valid, in_data, in_last, in_keep, blk_ready,
                   output in_ready, blk_valid, blk_word, blk_idx, blk_sof, blk_eom);
endinterface

// File: rtl/sha256_blk_buf.sv
// 16x32 block buffer: byte-strobed word write, dedicated length-field write to
// words 14/15, single read port and whole-buffer clear.
module sha256_blk_buf
   import sha256_msg_padder_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic                   wr_en,
   input  logic [3:0]             wr_idx,
   input  logic [BYTE_LANES-1:0]  wr_be,
   input  logic [31:0]            wr_data,
   input  logic                   len_we,
   input  logic [LEN_FIELD_W-1:0] len_data,
   input  logic [3:0]             rd_idx,
   output logic [31:0]            rd_data
);
   logic [BLK_WORDS-1:0][31:0] mem;

   for (genvar w = 0; w < BLK_WORDS; w++) begin : g_word
      localparam bit IS_LEN = (w == LEN_WORD_HI) || (w == LEN_WORD_LO);
      localparam int LEN_OFS = (w == LEN_WORD_HI) ? 32 : 0;
      for (genvar l = 0; l < BYTE_LANES; l++) begin : g_lane
         logic [7:0] b;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                                     b <= 8'h00;
            else if (clr)                                   b <= 8'h00;
            else if (IS_LEN && len_we)                      b <= len_data[LEN_OFS+8*l +: 8];
            else if (wr_en && wr_idx == 4'(w) && wr_be[l])  b <= wr_data[8*l +: 8];
         end
         assign mem[w][8*l +: 8] = b;
      end
   end

   assign rd_data = mem[rd_idx];
endmodule

// File: rtl/sha256_msg_padder.sv
// SHA-256 front end: packs bytes big-endian into a block buffer, appends FIPS 180-4
// padding and bit length, and streams 512-bit blocks out one word per beat.
module sha256_msg_padder
   import sha256_msg_padder_pkg::*;
#(
   parameter int LEN_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   sha256_msg_padder_if.slave bus
);
   logic [2:0]       state, emit_next;
   logic [5:0]       pos;
   logic [LEN_W-1:0] count;
   logic [3:0]       emit_idx, pad_widx, pad_lim, wr_idx;
   logic             final_blk, sof_pend, pad_first, pad_long;
   logic             in_acc, emit_acc, blk_done, pad_fits, pad_end, long_now, wr_en;
   logic [3:0]       wr_be;
   logic [31:0]      wr_data, rd_data;

   assign bus.in_ready  = rst_n && (state == ST_IDLE || state == ST_FILL);
   assign in_acc        = bus.in_valid && bus.in_ready;
   assign bus.blk_valid = (state == ST_EMIT);
   assign emit_acc      = bus.blk_valid && bus.blk_ready;
   assign blk_done      = emit_acc && emit_idx == 4'd15;
   assign bus.blk_word  = bus.blk_valid ? rd_data : 32'h0;
   assign bus.blk_idx   = emit_idx;
   assign bus.blk_sof   = bus.blk_valid && sof_pend && emit_idx == 4'd0;
   assign bus.blk_eom   = bus.blk_valid && final_blk && emit_idx == 4'd15;

   // The 0x80 cycle decides whether the length still fits; later cycles reuse that decision.
   assign pad_fits = (pos <= 6'd55);
   assign long_now = pad_first ? !pad_fits : pad_long;
   assign pad_lim  = long_now ? 4'd15 : 4'd13;
   assign pad_end  = (state == ST_PAD) && ((pad_first ? pos[5:2] : pad_widx) == pad_lim);

   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = pos[5:2];
      wr_be   = 4'h0;
      wr_data = 32'h0;
      if (in_acc && bus.in_keep) begin
         wr_en   = 1'b1;
         wr_be   = 4'b1000 >> pos[1:0];
         wr_data = {4{bus.in_data}};
      end else if (state == ST_PAD) begin
         wr_en = 1'b1;
         if (pad_first) begin
            wr_be   = 4'b1111 >> pos[1:0];
            wr_data = {PAD_BYTE, 24'h0} >> {pos[1:0], 3'b000};
         end else begin
            wr_idx = pad_widx;
            wr_be  = 4'hF;
         end
      end
   end

   sha256_blk_buf u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (blk_done),
      .wr_en   (wr_en),
      .wr_idx  (wr_idx),
      .wr_be   (wr_be),
      .wr_data (wr_data),
      .len_we  (state == ST_LEN),
      .len_data(bit_len(CNT_EXT_W'(count))),
      .rd_idx  (emit_idx),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         emit_next <= ST_IDLE;
         pos       <= '0;
         count     <= '0;
         emit_idx  <= '0;
         pad_widx  <= '0;
         final_blk <= 1'b0;
         sof_pend  <= 1'b0;
         pad_first <= 1'b0;
         pad_long  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_FILL: begin
               // keep=0 without last is a dropped beat and changes nothing
               if (in_acc && (bus.in_keep || bus.in_last)) begin
                  if (state == ST_IDLE) sof_pend <= 1'b1;
                  pad_first <= 1'b1;
                  if (bus.in_keep) begin
                     count <= count + 1'b1;
                     pos   <= pos + 1'b1;
                  end
                  if (bus.in_keep && pos == 6'd63) begin
                     state     <= ST_EMIT;
                     emit_next <= bus.in_last ? ST_PAD : ST_FILL;
                  end else if (bus.in_last) state <= ST_PAD;
                  else                      state <= ST_FILL;
               end
            end
            ST_PAD: begin
               pad_first <= 1'b0;
               pad_long  <= long_now;
               pad_widx  <= (pad_first ? pos[5:2] : pad_widx) + 4'd1;
               if (pad_end) begin
                  if (long_now) begin
                     state     <= ST_EMIT;
                     emit_next <= ST_PAD;
                     pad_long  <= 1'b0;
                     pad_widx  <= 4'd0;
                  end else state <= ST_LEN;
               end
            end
            ST_LEN: begin
               state     <= ST_EMIT;
               emit_next <= ST_IDLE;
               final_blk <= 1'b1;
            end
            ST_EMIT: begin
               if (emit_acc) begin
                  emit_idx <= emit_idx + 4'd1;
                  if (emit_idx == 4'd0) sof_pend <= 1'b0;
                  if (blk_done) begin
                     state <= emit_next;
                     if (emit_next == ST_IDLE) begin
                        count     <= '0;
                        pos       <= '0;
                        final_blk <= 1'b0;
                     end
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sha256_msg_padder.sv
// Randomized bench for the padder: output blocks are compared against a byte-level
// FIPS 180-4 padding model plus a few hand-computed words.
module tb_sha256_msg_padder;
   typedef struct packed {
      logic [31:0] w;
      logic [3:0]  idx;
      logic        sof;
      logic        eom;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sha256_msg_padder_if bus();
   sha256_msg_padder #(.LEN_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int    checks = 0;
   int    failures = 0;
   int    eom_seen = 0;
   beat_t exp_q[$];
   beat_t obs_q[$];
   bit    stall_en = 1'b0;
   bit    hold_rdy_low = 1'b0;
   bit    drv_to = 1'b0;

   initial begin
      bus.blk_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         bus.blk_ready = hold_rdy_low ? 1'b0 : stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin : mon
      beat_t b;
      forever begin
         @(negedge clk);
         if (rst_n && bus.blk_valid && bus.blk_ready) begin
            b.w = bus.blk_word; b.idx = bus.blk_idx; b.sof = bus.blk_sof; b.eom = bus.blk_eom;
            obs_q.push_back(b);
            if (bus.blk_eom) eom_seen++;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // Reference: message || 0x80 || zeros until len%64==56 || 64-bit bit length.
   task automatic build_exp(input logic [7:0] m[$]);
      logic [7:0]  p[$];
      logic [63:0] bl;
      beat_t       b;
      int          nw;
      p = m;
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      bl = 64'(m.size()) * 64'd8;
      for (int i = 7; i >= 0; i--) p.push_back(bl[i*8 +: 8]);
      nw = p.size() / 4;
      exp_q.delete();
      for (int i = 0; i < nw; i++) begin
         b.w   = {p[4*i], p[4*i+1], p[4*i+2], p[4*i+3]};
         b.idx = 4'(i % 16);
         b.sof = (i == 0);
         b.eom = (i == nw - 1);
         exp_q.push_back(b);
      end
   endtask

   task automatic drive_beat(input logic [7:0] d, input bit last, input bit keep, input bit gap);
      int n = 0;
      if (gap) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = last; bus.in_keep = keep;
      @(negedge clk);
      while (!bus.in_ready && n < 4000) begin n++; @(negedge clk); end
      if (n >= 4000) drv_to = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_keep = 1'b0;
   endtask

   task automatic send_msg(input logic [7:0] m[$], input bit gaps, input bit drops,
                           input bit marker_end, input bit with_last);
      drv_to = 1'b0;
      if (m.size() == 0) drive_beat(8'($urandom), with_last, 1'b0, gaps);
      for (int i = 0; i < m.size(); i++) begin
         if (drops && $urandom_range(0, 7) == 0) drive_beat(8'($urandom), 1'b0, 1'b0, gaps);
         drive_beat(m[i], with_last && !marker_end && i == m.size() - 1, 1'b1, gaps);
      end
      if (with_last && marker_end && m.size() != 0) drive_beat(8'($urandom), 1'b1, 1'b0, gaps);
   endtask

   task automatic wait_out(input int n);
      int k = 0;
      while (obs_q.size() < n && k < 20000) begin @(posedge clk); k++; end
      repeat (40) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.in_ready, bus.blk_valid, bus.blk_word, bus.blk_idx, bus.blk_sof, bus.blk_eom} !== 39'h0) begin
         failures++;
         $display("FAIL reset_outputs got rdy=%b v=%b w=%h i=%0d s=%b e=%b want all 0",
                  bus.in_ready, bus.blk_valid, bus.blk_word, bus.blk_idx, bus.blk_sof, bus.blk_eom);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.blk_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_release got in_ready=%b blk_valid=%b want 1/0", bus.in_ready, bus.blk_valid);
      end
   endtask

   task automatic test_abc(input string nm);
      logic [7:0] m[$];
      beat_t g;
      m = '{8'h61, 8'h62, 8'h63};
      build_exp(m);
      obs_q.delete();
      send_msg(m, 1'b0, 1'b0, 1'b0, 1'b1);
      wait_out(16);
      checks++;
      if (drv_to || obs_q.size() != 16) begin
         failures++;
         $display("FAIL %s beats got=%0d want=16 drv_timeout=%b", nm, obs_q.size(), drv_to);
      end
      foreach (exp_q[i]) begin
         g = (i < obs_q.size()) ? obs_q[i] : '0;
         checks++;
         if (g !== exp_q[i]) begin
            failures++;
            $display("FAIL %s w%0d got=%h/%0d/%b/%b want=%h/%0d/%b/%b", nm, i,
                     g.w, g.idx, g.sof, g.eom, exp_q[i].w, exp_q[i].idx, exp_q[i].sof, exp_q[i].eom);
         end
      end
      g = (obs_q.size() >= 16) ? obs_q[0] : '0;
      checks++;
      if (g.w !== 32'h61626380 || g.sof !== 1'b1) begin
         failures++;
         $display("FAIL %s_w0 got=%h sof=%b want=61626380 sof=1", nm, g.w, g.sof);
      end
      g = (obs_q.size() >= 16) ? obs_q[15] : '0;
      checks++;
      if (g.w !== 32'h00000018 || g.eom !== 1'b1) begin
         failures++;
         $display("FAIL %s_w15 got=%h eom=%b want=00000018 eom=1", nm, g.w, g.eom);
      end
   endtask

   task automatic test_lengths();
      int          lens[4]  = '{55, 56, 64, 0};
      int          nbk[4]   = '{1, 2, 2, 1};
      int          si0[4]   = '{13, 14, 16, 0};
      logic [31:0] sw0[4]   = '{32'h34353680, 32'h80000000, 32'h80000000, 32'h80000000};
      int          si1[4]   = '{15, 31, 31, 15};
      logic [31:0] sw1[4]   = '{32'h000001B8, 32'h000001C0, 32'h00000200, 32'h00000000};
      logic [7:0]  m[$];
      beat_t       g;
      for (int t = 0; t < 4; t++) begin
         m.delete();
         for (int i = 0; i < lens[t]; i++) m.push_back(8'(i));
         build_exp(m);
         obs_q.delete();
         send_msg(m, 1'b0, 1'b0, 1'b0, 1'b1);
         wait_out(16 * nbk[t]);
         checks++;
         if (drv_to || obs_q.size() != 16 * nbk[t]) begin
            failures++;
            $display("FAIL len%0d_beats got=%0d want=%0d drv_timeout=%b", lens[t], obs_q.size(), 16 * nbk[t], drv_to);
         end
         foreach (exp_q[i]) begin
            g = (i < obs_q.size()) ? obs_q[i] : '0;
            checks++;
            if (g !== exp_q[i]) begin
               failures++;
               $display("FAIL len%0d w%0d got=%h/%0d/%b/%b want=%h/%0d/%b/%b", lens[t], i,
                        g.w, g.idx, g.sof, g.eom, exp_q[i].w, exp_q[i].idx, exp_q[i].sof, exp_q[i].eom);
            end
         end
         g = (si0[t] < obs_q.size()) ? obs_q[si0[t]] : '0;
         checks++;
         if (g.w !== sw0[t]) begin
            failures++;
            $display("FAIL len%0d_spot%0d got=%h want=%h", lens[t], si0[t], g.w, sw0[t]);
         end
         g = (si1[t] < obs_q.size()) ? obs_q[si1[t]] : '0;
         checks++;
         if (g.w !== sw1[t] || g.eom !== 1'b1) begin
            failures++;
            $display("FAIL len%0d_last got=%h eom=%b want=%h eom=1", lens[t], g.w, g.eom, sw1[t]);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] m[$];
      beat_t      g;
      int         len;
      for (int t = 0; t < 5; t++) begin
         len = $urandom_range(0, 130);
         m.delete();
         for (int i = 0; i < len; i++) m.push_back(8'($urandom));
         build_exp(m);
         obs_q.delete();
         send_msg(m, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
         wait_out(exp_q.size());
         checks++;
         if (drv_to || obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL rand%0d_beats len=%0d got=%0d want=%0d drv_timeout=%b", t, len, obs_q.size(), exp_q.size(), drv_to);
         end
         foreach (exp_q[i]) begin
            g = (i < obs_q.size()) ? obs_q[i] : '0;
            checks++;
            if (g !== exp_q[i]) begin
               failures++;
               $display("FAIL rand%0d w%0d got=%h/%0d/%b/%b want=%h/%0d/%b/%b", t, i,
                        g.w, g.idx, g.sof, g.eom, exp_q[i].w, exp_q[i].idx, exp_q[i].sof, exp_q[i].eom);
            end
         end
      end
   endtask

   task automatic test_back_to_back_stall();
      logic [7:0] m[$];
      beat_t      first[$];
      beat_t      g;
      for (int i = 0; i < 130; i++) m.push_back(8'($urandom));
      build_exp(m);
      for (int r = 0; r < 2; r++) begin
         stall_en = (r == 1);
         obs_q.delete();
         send_msg(m, 1'b0, 1'b0, 1'b0, 1'b1);
         wait_out(48);
         checks++;
         if (drv_to || obs_q.size() != 48) begin
            failures++;
            $display("FAIL stall%0d_beats got=%0d want=48 drv_timeout=%b", r, obs_q.size(), drv_to);
         end
         foreach (exp_q[i]) begin
            g = (i < obs_q.size()) ? obs_q[i] : '0;
            checks++;
            if (g !== exp_q[i] || (r == 1 && i < first.size() && g !== first[i])) begin
               failures++;
               $display("FAIL stall%0d w%0d got=%h/%0d/%b/%b want=%h/%0d/%b/%b", r, i,
                        g.w, g.idx, g.sof, g.eom, exp_q[i].w, exp_q[i].idx, exp_q[i].sof, exp_q[i].eom);
            end
         end
         first = obs_q;
      end
      stall_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [7:0] m[$];
      int         k = 0;
      int         eom_before;
      for (int i = 0; i < 64; i++) m.push_back(8'($urandom));
      hold_rdy_low = 1'b1;
      @(posedge clk); #1;
      obs_q.delete();
      send_msg(m, 1'b0, 1'b0, 1'b0, 1'b0);
      while (!bus.blk_valid && k < 100) begin @(posedge clk); #1; k++; end
      checks++;
      if (bus.blk_valid !== 1'b1 || drv_to) begin
         failures++;
         $display("FAIL mid_emit_entry got blk_valid=%b want 1", bus.blk_valid);
      end
      repeat (2) begin @(posedge clk); #1; end
      eom_before = eom_seen;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.in_ready, bus.blk_valid, bus.blk_word, bus.blk_idx, bus.blk_sof, bus.blk_eom} !== 39'h0) begin
         failures++;
         $display("FAIL mid_reset_outputs got rdy=%b v=%b w=%h i=%0d s=%b e=%b want all 0",
                  bus.in_ready, bus.blk_valid, bus.blk_word, bus.blk_idx, bus.blk_sof, bus.blk_eom);
      end
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b1;
      hold_rdy_low = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (eom_seen != eom_before || obs_q.size() != 0) begin
         failures++;
         $display("FAIL mid_no_eom got eom=%0d beats=%0d want eom=%0d beats=0", eom_seen, obs_q.size(), eom_before);
      end
      test_abc("abc_after_reset");
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0; bus.in_keep = 1'b0;
      test_reset();
      test_abc("abc");
      test_lengths();
      test_random();
      test_back_to_back_stall();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
